// File: rtl/timing_loop_nco.sv
// ---------------------------------------------------------------------------
// timing_loop_nco
//
// Closes the MSK symbol-timing recovery loop. The Gardner timing error is
// filtered by a PI loop filter whose registered output steers the increment
// of a phase-accumulator NCO. Each accumulator wrap produces a one-cycle
// symbol strobe plus the fractional residual (mu) for the interpolator.
//
// reset_n is assumed to be released synchronously to clk by the upstream
// reset tree; assertion is asynchronous.
//
// Ports
//   clk          in   1    sample clock, rising edge
//   reset_n      in   1    asynchronous active-low reset
//   e_in         in   WE   signed Gardner timing error
//   e_valid_i    in   1    e_in qualifier (single-cycle pulses)
//   iq_val       in   1    sample valid; NCO advances only when high
//   loop_en_i    in   1    0 = open loop (nominal rate), 1 = closed loop
//   sym_valid_o  out  1    one-cycle symbol strobe
//   mu_o         out  WMU  phase residual captured at the strobing wrap
//   ctrl_o       out  WA   signed registered loop-filter output
// ---------------------------------------------------------------------------
module timing_loop_nco #(
    parameter int OSF        = 20,
    parameter int WE         = 18,
    parameter int WA         = 24,
    parameter int WP         = 32,
    parameter int WMU        = 16,
    parameter int KP_SHIFT   = 4,
    parameter int KI_SHIFT   = 8,
    parameter int CTRL_SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic signed [WE-1:0] e_in,
    input  logic                 e_valid_i,
    input  logic                 iq_val,
    input  logic                 loop_en_i,
    output logic                 sym_valid_o,
    output logic [WMU-1:0]       mu_o,
    output logic signed [WA-1:0] ctrl_o
);

    // Nominal increment rounded up, so the open-loop residual creeps
    // forward by a few LSBs per symbol instead of slipping backwards.
    localparam logic signed [WP+1:0] NOM =
        (WP+2)'(((64'd1 << WP) + 64'(OSF) - 64'd1) / 64'(OSF));
    localparam logic signed [WP+1:0] INC_MIN = NOM >>> 1;
    localparam logic signed [WP+1:0] INC_MAX = NOM + (NOM >>> 1);

    // Symmetric saturation limits expressed at the WA+1-bit sum width.
    localparam logic signed [WA:0] SAT_POS = {2'b00, {(WA-1){1'b1}}};
    localparam logic signed [WA:0] SAT_NEG = -SAT_POS;

    function automatic logic signed [WA-1:0] sat(input logic signed [WA:0] v);
        if (v > SAT_POS)      return SAT_POS[WA-1:0];
        else if (v < SAT_NEG) return SAT_NEG[WA-1:0];
        else                  return v[WA-1:0];
    endfunction

    logic signed [WA-1:0] r_integ;
    logic signed [WA-1:0] r_ctrl;
    logic [WP-1:0]        r_acc;
    logic                 r_sym_valid;
    logic [WMU-1:0]       r_mu;

    // ---------------- loop filter ----------------
    logic signed [WA-1:0] w_ex;
    logic signed [WA-1:0] w_ki;
    logic signed [WA-1:0] w_kp;
    logic signed [WA:0]   w_integ_sum;
    logic signed [WA-1:0] w_integ_n;
    logic signed [WA:0]   w_ctrl_sum;
    logic signed [WA-1:0] w_ctrl_n;

    assign w_ex        = {{(WA-WE){e_in[WE-1]}}, e_in};
    assign w_ki        = w_ex >>> KI_SHIFT;
    assign w_kp        = w_ex >>> KP_SHIFT;
    assign w_integ_sum = {r_integ[WA-1], r_integ} + {w_ki[WA-1], w_ki};
    assign w_integ_n   = sat(w_integ_sum);
    // Proportional path adds to the freshly updated integrator value.
    assign w_ctrl_sum  = {w_kp[WA-1], w_kp} + {w_integ_n[WA-1], w_integ_n};
    assign w_ctrl_n    = sat(w_ctrl_sum);

    // ---------------- NCO ----------------
    logic signed [WP+1:0] w_ctrl_ext;
    logic signed [WP+1:0] w_inc_raw;
    logic signed [WP+1:0] w_inc_c;
    logic [WP:0]          w_acc_sum;
    logic                 w_unused_inc_msbs;

    // The NCO always sees the registered control word, i.e. the value
    // before any loop-filter update happening on the same edge.
    assign w_ctrl_ext = {{(WP+2-WA){r_ctrl[WA-1]}}, r_ctrl};
    assign w_inc_raw  = NOM + (w_ctrl_ext <<< CTRL_SHIFT);

    always_comb begin
        // NOTE: assign a default before any conditional update so every path
        // drives the signal and no latch is inferred.
        w_inc_c = w_inc_raw;
        if (w_inc_raw < INC_MIN)      w_inc_c = INC_MIN;
        else if (w_inc_raw > INC_MAX) w_inc_c = INC_MAX;
    end

    // After clamping the increment is positive and below 2^WP, so the two
    // top bits are always zero.
    assign w_unused_inc_msbs = ^w_inc_c[WP+1:WP];
    assign w_acc_sum         = {1'b0, r_acc} + {1'b0, w_inc_c[WP-1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_integ     <= '0;
            r_ctrl      <= '0;
            r_acc       <= '0;
            r_sym_valid <= 1'b0;
            r_mu        <= '0;
        end else begin
            // Open loop wins over a coincident error sample.
            if (!loop_en_i) begin
                r_integ <= '0;
                r_ctrl  <= '0;
            end else if (e_valid_i) begin
                r_integ <= w_integ_n;
                r_ctrl  <= w_ctrl_n;
            end

            if (iq_val) begin
                r_acc       <= w_acc_sum[WP-1:0];
                r_sym_valid <= w_acc_sum[WP];
                if (w_acc_sum[WP]) begin
                    r_mu <= w_acc_sum[WP-1 -: WMU];
                end
            end else begin
                r_sym_valid <= 1'b0;
            end
        end
    end

    assign sym_valid_o = r_sym_valid;
    assign mu_o        = r_mu;
    assign ctrl_o      = r_ctrl;

endmodule

// File: doc/timing_loop_nco.md
# timing_loop_nco

Closes the symbol-timing recovery loop in the MSK receiver: consumes the Gardner timing-error stream, runs it through a PI loop filter, and steers a phase-accumulator NCO. The NCO generates the one-symbol strobe and fractional-interval estimate that drive the TED's symbol-valid input and the interpolator. It sits between the TED error output and the TED/interpolator strobe inputs in the 200 MHz sample domain.

## Interface
- OSF, 20: nominal samples per symbol.
- WE, 18: signed timing-error input width.
- WA, 24: signed integrator and control-word width.
- WP, 32: phase accumulator width (unsigned, modulo 2^WP).
- WMU, 16: fractional-interval output width.
- KP_SHIFT, 4: proportional gain = 2^-KP_SHIFT (arithmetic right shift).
- KI_SHIFT, 8: integral gain = 2^-KI_SHIFT (arithmetic right shift).
- CTRL_SHIFT, 8: control word left shift into phase-increment units.
- clk  in  1  sample clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- e_in  in  WE  signed Gardner error.
- e_valid_i  in  1  e_in qualifier, single-cycle pulses.
- iq_val  in  1  sample-valid; NCO advances only when high.
- loop_en_i  in  1  0 = open loop (nominal rate), 1 = closed loop.
- sym_valid_o  out  1  one-cycle symbol strobe.
- mu_o  out  WMU  phase residual at the strobing wrap.
- ctrl_o  out  WA  signed loop-filter output (registered).

## Operation
- Reset (async assert, sync release): integ, ctrl_o, acc, sym_valid_o, mu_o all 0.
- Loop filter, on e_valid_i && loop_en_i: ex = sign-extend(e_in) to WA; integ_n = sat(integ + (ex >>> KI_SHIFT)); ctrl_o <= sat((ex >>> KP_SHIFT) + integ_n); integ <= integ_n. sat clamps to ±(2^(WA-1)-1); both sums use WA+1-bit intermediates.
- No e_valid_i: integ and ctrl_o hold.
- loop_en_i low: integ and ctrl_o cleared to 0 on next clock; e_valid_i ignored (loop_en_i takes priority over simultaneous e_valid_i).
- NOM = ceil(2^WP / OSF) (214748365 for defaults). INC_MIN = floor(NOM/2), INC_MAX = NOM + floor(NOM/2).
- inc = clamp(NOM + (sign-extend(ctrl_o) <<< CTRL_SHIFT), INC_MIN, INC_MAX), computed in WP+2 signed bits; inc always positive.
- On iq_val: {carry, acc} <= acc + inc. iq_val low: acc holds, no strobe.
- carry = 1: sym_valid_o <= 1, mu_o <= new acc[WP-1 -: WMU]; otherwise sym_valid_o <= 0, mu_o holds.
- ctrl_o update and NCO step in the same cycle: NCO uses the pre-update (registered) ctrl_o.

## Timing
- e_valid_i at cycle t -> ctrl_o valid at t+1; affects NCO increment from t+1.
- Wrap on an iq_val at cycle n -> sym_valid_o high during cycle n+1 only, mu_o valid the same cycle and held until next wrap.
- Open loop, iq_val continuous: first strobe the cycle after the 20th iq_val following reset release; then every 20 cycles (residual grows by 4 per symbol; period stays 20 for >5x10^7 symbols).
- sym_valid_o never high two consecutive cycles (inc <= INC_MAX < 2^WP).
- Async reset mid-symbol: outputs go to 0 without waiting for clk; count restarts from 0 on release.

## Test plan
- Open loop: loop_en_i=0, iq_val=1 continuous after reset -> first sym_valid_o at 21st cycle, period exactly 20 for 1000 symbols, ctrl_o=0, first mu_o=0.
- iq_val alternating 1/0 -> strobe period 40 cycles, acc frozen on iq_val=0 cycles, never strobes in cycle after iq_val=0.
- PI step: loop_en_i=1, single e_valid_i with e_in=+4096 -> next cycle ctrl_o=272, integ=16; then e_in=0 pulse -> ctrl_o=16; e_in=-4096 pulse -> integ=0, ctrl_o=-256.
- Saturation: e_in=+131071 on every cycle -> integ and ctrl_o clamp at 8388607, inc=INC_MAX=322122547, strobe periods only 13 or 14; e_in=-131072 -> ctrl_o=-8388607, inc=INC_MIN, periods 40 or 41.
- loop_en_i dropped with simultaneous e_valid_i -> ctrl_o and integ 0 next cycle, period returns to 20.
- reset_n low mid-symbol (cycle 10 of a period) -> sym_valid_o, mu_o, ctrl_o 0 immediately; after release, first strobe after 20 iq_val.
